// File: rtl/mips_core_pkg.sv
// Shared definitions for the fetch-side PC logic: redirect hold states,
// the sequential PC step and the redirect rank rule.
package mips_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DEC,
    HOLD_EX
  } redirect_state_t;

  localparam int unsigned PC_STEP = 4;

  // EX outranks DEC; at equal rank the incoming (newer) redirect wins.
  function automatic logic incoming_wins(input logic held_is_ex, input logic in_is_ex);
    return !(held_is_ex && !in_is_ex);
  endfunction

endpackage

// File: rtl/fetch_redirect_buffer.sv
// Holds redirects that arrive while IF is stalled and arbitrates between the held
// and the incoming redirect, producing the effective redirect for this cycle.
module fetch_redirect_buffer
  import mips_core_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 in_we_i,
  input  logic                 in_ex_i,
  input  logic [AddrWidth-1:0] in_pc_i,
  output logic                 eff_valid_o,
  output logic [AddrWidth-1:0] eff_pc_o,
  output logic                 eff_ex_o,
  output logic                 pending_o,
  output logic                 deferred_o,
  output logic                 dropped_o
);

  redirect_state_t        state_q, state_d;
  logic [AddrWidth-1:0]   held_pc_q, held_pc_d;
  logic                   held_valid;
  logic                   held_ex;
  logic                   in_wins;

  assign held_valid = (state_q != IDLE);
  assign held_ex    = (state_q == HOLD_EX);
  assign in_wins    = incoming_wins(held_ex, in_ex_i);
  assign pending_o  = held_valid;

  always_comb begin
    state_d     = state_q;
    held_pc_d   = held_pc_q;
    eff_valid_o = 1'b0;
    eff_pc_o    = held_pc_q;
    eff_ex_o    = held_ex;
    deferred_o  = 1'b0;
    dropped_o   = 1'b0;

    if (!stall_i) begin
      state_d = IDLE;
      if (in_we_i && (!held_valid || in_wins)) begin
        eff_valid_o = 1'b1;
        eff_pc_o    = in_pc_i;
        eff_ex_o    = in_ex_i;
      end else if (held_valid) begin
        eff_valid_o = 1'b1;
      end
      // With two candidates exactly one loses.
      dropped_o = in_we_i && held_valid;
    end else if (in_we_i) begin
      if (held_valid && !in_wins) begin
        dropped_o = 1'b1;
      end else begin
        dropped_o  = held_valid;
        deferred_o = 1'b1;
        held_pc_d  = in_pc_i;
        state_d    = in_ex_i ? HOLD_EX : HOLD_DEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      held_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      held_pc_q <= held_pc_d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: sequential advance, DEC/EX redirects with stall hold, epoch
// and misalignment tracking. Event counters are built only with FETCH_PC_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_pc_unit
  import mips_core_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = `ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_stall,
  input  logic                  redirect_we,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_ex,
  output logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  fetch_valid,
  output logic                  fetch_epoch,
  output logic                  redirect_pending,
  output logic                  misalign_err,
  output logic [31:0]           stat_applied,
  output logic [31:0]           stat_deferred,
  output logic [31:0]           stat_dropped
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q;
  logic                  epoch_q, epoch_d;
  logic                  err_q, err_d;

  logic                  eff_valid;
  logic [ADDR_WIDTH-1:0] eff_pc;
  logic                  eff_ex;
  logic                  deferred;
  logic                  dropped;
  logic                  applied;

  fetch_redirect_buffer #(
    .AddrWidth (ADDR_WIDTH)
  ) u_redirect_buffer (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (if_stall),
    .in_we_i     (redirect_we),
    .in_ex_i     (redirect_ex),
    .in_pc_i     (redirect_pc),
    .eff_valid_o (eff_valid),
    .eff_pc_o    (eff_pc),
    .eff_ex_o    (eff_ex),
    .pending_o   (redirect_pending),
    .deferred_o  (deferred),
    .dropped_o   (dropped)
  );

  assign applied = eff_valid && !if_stall;

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    if (!if_stall) begin
      if (applied) begin
        pc_d    = {eff_pc[ADDR_WIDTH-1:2], 2'b00};
        epoch_d = epoch_q ^ eff_ex;
        err_d   = err_q | (eff_pc[1:0] != 2'b00);
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      epoch_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      epoch_q <= epoch_d;
      err_q   <= err_d;
    end
  end

  assign fetch_pc     = pc_q;
  assign fetch_valid  = valid_q;
  assign fetch_epoch  = epoch_q;
  assign misalign_err = err_q;

`ifdef FETCH_PC_STATS_EN
  logic [31:0] applied_q, deferred_q, dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      applied_q  <= '0;
      deferred_q <= '0;
      dropped_q  <= '0;
    end else begin
      if (applied)  applied_q  <= applied_q + 32'd1;
      if (deferred) deferred_q <= deferred_q + 32'd1;
      if (dropped)  dropped_q  <= dropped_q + 32'd1;
    end
  end

  assign stat_applied  = applied_q;
  assign stat_deferred = deferred_q;
  assign stat_dropped  = dropped_q;
`else
  logic unused_stats;
  assign unused_stats  = ^{applied, deferred, dropped};
  assign stat_applied  = '0;
  assign stat_deferred = '0;
  assign stat_dropped  = '0;
`endif

endmodule
